// File: rtl/bd2b_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Widths are sized for a 3-digit BCD operand and an 8-bit binary result.
package bd2b_pkg;

    localparam int DIGITS    = 3;
    localparam int BCD_W     = 4 * DIGITS;
    localparam int BIN_W     = 8;
    localparam int ITER      = 10;
    localparam int DIGIT_MAX = 9;
    localparam int SR_W      = BCD_W + ITER;
    localparam int CNT_W     = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // High when any packed digit is outside 0..9.
    function automatic logic bcd_invalid(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'(DIGIT_MAX)) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bd2b_digit_adj.sv
// Reverse double-dabble nibble corrector: a digit that reached 8 or more after
// the right shift had a 10s-carry shifted into it, so take 3 back out.
module bd2b_digit_adj (
    input  logic [3:0] in,
    output logic [3:0] out
);

    always_comb begin
        out = (in >= 4'd8) ? (in - 4'd3) : in;
    end

endmodule

// File: rtl/bd2b_sr.sv
// Sequential BCD-to-binary converter: one shift-right-and-correct step per clock,
// constant latency, with overflow saturation and invalid-digit reporting.
module bd2b_sr
    import bd2b_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BCD_W-1:0] bdc,
    output logic [BIN_W-1:0] bc,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t           state_q, state_d;
    logic [SR_W-1:0]  sr_q;
    logic [SR_W-1:0]  sr_shift;
    logic [SR_W-1:0]  sr_adj;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic [BIN_W-1:0] bc_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic             err_out_q;
    logic             load;
    logic             step;
    logic             finish;
    logic [ITER-1:0]  value;

    assign sr_shift = sr_q >> 1;
    assign sr_adj[ITER-1:0] = sr_shift[ITER-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bd2b_digit_adj u_adj (
            .in  (sr_shift[ITER + 4*g +: 4]),
            .out (sr_adj[ITER + 4*g +: 4])
        );
    end

    assign value = sr_adj[ITER-1:0];

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            bc_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
            if (load) begin
                sr_q   <= {bdc, {ITER{1'b0}}};
                cnt_q  <= '0;
                err_q  <= bcd_invalid(bdc);
                busy_q <= 1'b1;
            end else if (step) begin
                sr_q  <= sr_adj;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (finish) begin
                busy_q <= 1'b0;
                if (err_q) begin
                    bc_q      <= '0;
                    ovf_q     <= 1'b0;
                    err_out_q <= 1'b1;
                end else if (|value[ITER-1:BIN_W]) begin
                    bc_q      <= '1;
                    ovf_q     <= 1'b1;
                    err_out_q <= 1'b0;
                end else begin
                    bc_q      <= value[BIN_W-1:0];
                    ovf_q     <= 1'b0;
                    err_out_q <= 1'b0;
                end
            end
        end
    end

    assign bc   = bc_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign err  = err_out_q;

endmodule
